nr_seed: RTL and testbench
==========================

NR_SEED -- requirements
Module: nr_seed

Interface
REQ-001 SHALL have parameter INTEGER, default 10, integer bits of the fixed-point format.
REQ-002 SHALL have parameter DECIMAL, default 7, fractional bits of the fixed-point format.
REQ-003 SHALL have parameter PRECISION, default 1+INTEGER+DECIMAL, total signed two's-complement width.
REQ-004 SHALL use one clock and a synchronous, active-low reset; ports clk and rst_n.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port in_vld  input  1  in_d valid this cycle.
REQ-008 SHALL have port in_d  input  PRECISION  signed divisor D.
REQ-009 SHALL have port out_vld  output  1  outputs valid this cycle.
REQ-010 SHALL have port out_d  output  PRECISION  normalized |D|, in [0.5,1), unsigned magnitude, sign bit 0.
REQ-011 SHALL have port out_x  output  PRECISION  seed X0 for the downstream Newton-Raphson stage.
REQ-012 SHALL have port out_shift  output  $clog2(PRECISION)+1  signed exponent s, where |D| = out_d * 2^s.
REQ-013 SHALL have port out_neg  output  1  D was negative.
REQ-014 SHALL have port out_dz  output  1  D was zero (divide-by-zero).

Function
REQ-015 SHALL accept one input per cycle when in_vld=1, with no backpressure and full throughput.
REQ-016 SHALL present results exactly 4 cycles after acceptance, with out_vld asserted for exactly one cycle per accepted input.
REQ-017 SHALL keep all outputs at their previous values while out_vld=0; consumers ignore them.
REQ-018 SHALL implement the pipeline as:
- S1: register in_d; compute abs, neg, zero.
- S2: leading-one position p of |D| (bit index 0..PRECISION-2).
- S3: normalize shift.
- S4: seed multiply/subtract.
REQ-019 SHALL compute abs as -D for negative D, with out_neg=1; D = -2^(PRECISION-1) saturates to 2^(PRECISION-1)-1, out_neg=1.
REQ-020 SHALL compute s = p-(DECIMAL-1) and place the leading one at bit DECIMAL-1 of out_d:
- s>0: right shift by s, shifted-out bits truncated.
- s<0: left shift by -s, zeros filled in.
- s=0: pass through.
REQ-021 SHALL compute seed X0 = C1 - ((C2*out_d)[PRECISION+DECIMAL-1:DECIMAL]):
- C1 = round(48/17*2^DECIMAL); C2 = round(32/17*2^DECIMAL).
- Product held at 2*PRECISION bits, then truncated as indicated.
- For DECIMAL=7: C1=361, C2=241.
REQ-022 SHALL, for D=0, force out_dz=1, out_d=0, out_x=0, out_shift=0, out_neg=0.
REQ-023 SHALL carry out_neg, out_dz and out_shift through the pipeline aligned with their data, so back-to-back inputs never mix fields.
REQ-024 SHALL produce a result for in_vld=1 every cycle, with each input's result in order 4 cycles later and no bubbles inserted.

Reset
REQ-025 SHALL, while rst_n=0 at a clk edge, clear all valid-pipeline bits and every output register (out_vld, out_d, out_x, out_shift, out_neg, out_dz) to 0.
REQ-026 SHALL discard in-flight inputs on reset mid-operation (no out_vld for them) and ignore in_vld while rst_n=0.
REQ-027 SHALL accept an input presented on the first edge with rst_n=1 and output it 4 cycles later.

Verification (INTEGER=10, DECIMAL=7)
REQ-028 SHALL cover: D=128 (1.0) -> after 4 cycles out_d=64, out_shift=1, out_x=241, out_neg=0, out_dz=0.
REQ-029 SHALL cover: D=384 (3.0) -> out_d=96, out_shift=2, out_x=181; then D=32 (0.25) -> out_d=64, out_shift=-1, out_x=241.
REQ-030 SHALL cover: D=-128 -> out_neg=1, out_d=64, out_shift=1, out_x=241; D=-131072 -> out_neg=1, out_d=127, out_shift=10.
REQ-031 SHALL cover: D=0 -> out_dz=1, out_d=0, out_x=0, out_shift=0.
REQ-032 SHALL cover: 4 back-to-back inputs {128,384,32,0} -> out_vld high 4 consecutive cycles, with results in order and fields aligned.
REQ-033 SHALL cover: rst_n low for one cycle with 2 inputs in flight -> no out_vld for them; an input on the next cycle appears 4 cycles later.

Source files
------------

// File: rtl/nr_seed.sv
// Newton-Raphson reciprocal seed generator: normalizes |D| into [0.5,1) and
// produces X0 = 48/17 - 32/17*Dn through a fixed 4-stage pipeline.
module nr_seed #(
    parameter int INTEGER   = 10,
    parameter int DECIMAL   = 7,
    parameter int PRECISION = 1 + INTEGER + DECIMAL
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_vld,
    input  logic [PRECISION-1:0]          in_d,
    output logic                          out_vld,
    output logic [PRECISION-1:0]          out_d,
    output logic [PRECISION-1:0]          out_x,
    output logic [$clog2(PRECISION):0]    out_shift,
    output logic                          out_neg,
    output logic                          out_dz
);

    localparam int PW  = $clog2(PRECISION);
    localparam int SW  = PW + 1;
    localparam int PW2 = 2 * PRECISION;
    // round(48/17 * 2^DECIMAL) and round(32/17 * 2^DECIMAL) in integer arithmetic
    localparam int C1  = ((96 << DECIMAL) + 17) / 34;
    localparam int C2  = ((64 << DECIMAL) + 17) / 34;

    localparam logic [PRECISION-1:0] MAXPOS = {1'b0, {(PRECISION-1){1'b1}}};
    localparam logic [PRECISION-1:0] MINNEG = {1'b1, {(PRECISION-1){1'b0}}};
    localparam logic [PRECISION-1:0] C1_V   = PRECISION'(C1);
    localparam logic [PW2-1:0]       C2_V   = PW2'(C2);
    localparam logic [SW-1:0]        BIAS   = SW'(DECIMAL - 1);

    // Stage 1: abs / sign / zero
    logic                 vld1_q, neg1_q, dz1_q;
    logic                 neg1_d, dz1_d;
    logic [PRECISION-1:0] abs1_q, abs1_d;
    // Stage 2: leading-one position
    logic                 vld2_q, neg2_q, dz2_q;
    logic [PRECISION-1:0] abs2_q;
    logic [PW-1:0]        p2_q, p2_d;
    // Stage 3: normalized magnitude and exponent
    logic                 vld3_q, neg3_q, dz3_q;
    logic [PRECISION-1:0] d3_q, d3_d;
    logic [SW-1:0]        sh3_q, sh3_d;
    logic [SW-1:0]        sh_raw, sh_neg;
    // Stage 4: seed
    logic [PW2-1:0]       prod;
    logic [PRECISION-1:0] x4_d;

    always_comb begin
        neg1_d = in_d[PRECISION-1];
        dz1_d  = (in_d == '0);
        if (!neg1_d)
            abs1_d = in_d;
        else if (in_d == MINNEG)
            abs1_d = MAXPOS;
        else
            abs1_d = -in_d;
    end

    always_comb begin
        p2_d = '0;
        for (int unsigned i = 0; i < PRECISION - 1; i++) begin
            if (abs1_q[i])
                p2_d = PW'(i);
        end
    end

    always_comb begin
        sh_raw = SW'(p2_q) - BIAS;
        sh_neg = -sh_raw;
        if (dz2_q) begin
            sh3_d = '0;
            d3_d  = '0;
        end else begin
            sh3_d = sh_raw;
            if (!sh_raw[SW-1])
                d3_d = abs2_q >> sh_raw;
            else
                d3_d = abs2_q << sh_neg;
        end
    end

    always_comb begin
        prod = C2_V * PW2'(d3_q);
        if (dz3_q)
            x4_d = '0;
        else
            x4_d = C1_V - prod[PRECISION+DECIMAL-1:DECIMAL];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld1_q    <= 1'b0;
            neg1_q    <= 1'b0;
            dz1_q     <= 1'b0;
            abs1_q    <= '0;
            vld2_q    <= 1'b0;
            neg2_q    <= 1'b0;
            dz2_q     <= 1'b0;
            abs2_q    <= '0;
            p2_q      <= '0;
            vld3_q    <= 1'b0;
            neg3_q    <= 1'b0;
            dz3_q     <= 1'b0;
            d3_q      <= '0;
            sh3_q     <= '0;
            out_vld   <= 1'b0;
            out_d     <= '0;
            out_x     <= '0;
            out_shift <= '0;
            out_neg   <= 1'b0;
            out_dz    <= 1'b0;
        end else begin
            vld1_q  <= in_vld;
            neg1_q  <= neg1_d;
            dz1_q   <= dz1_d;
            abs1_q  <= abs1_d;
            vld2_q  <= vld1_q;
            neg2_q  <= neg1_q;
            dz2_q   <= dz1_q;
            abs2_q  <= abs1_q;
            p2_q    <= p2_d;
            vld3_q  <= vld2_q;
            neg3_q  <= neg2_q;
            dz3_q   <= dz2_q;
            d3_q    <= d3_d;
            sh3_q   <= sh3_d;
            out_vld <= vld3_q;
            // Outputs hold their last result between valid cycles
            if (vld3_q) begin
                out_d     <= d3_q;
                out_x     <= x4_d;
                out_shift <= sh3_q;
                out_neg   <= neg3_q;
                out_dz    <= dz3_q;
            end
        end
    end

endmodule

// File: tb/tb_nr_seed.sv
// Directed bench for nr_seed (INTEGER=10, DECIMAL=7) with hand-computed results.
module tb_nr_seed;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic [17:0] in_d;
    logic        out_vld;
    logic [17:0] out_d;
    logic [17:0] out_x;
    logic [5:0]  out_shift;
    logic        out_neg;
    logic        out_dz;

    int n_cmp = 0;
    int n_err = 0;

    nr_seed #(.INTEGER(10), .DECIMAL(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_d      (in_d),
        .out_vld   (out_vld),
        .out_d     (out_d),
        .out_x     (out_x),
        .out_shift (out_shift),
        .out_neg   (out_neg),
        .out_dz    (out_dz)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int d, input int x, input int sh,
                           input bit neg, input bit dz);
        chk({tag, ".vld"},   {31'b0, out_vld}, 32'd1);
        chk({tag, ".d"},     {14'b0, out_d},   {14'b0, 18'(d)});
        chk({tag, ".x"},     {14'b0, out_x},   {14'b0, 18'(x)});
        chk({tag, ".shift"}, {26'b0, out_shift}, {26'b0, 6'(sh)});
        chk({tag, ".neg"},   {31'b0, out_neg}, {31'b0, neg});
        chk({tag, ".dz"},    {31'b0, out_dz},  {31'b0, dz});
    endtask

    // One isolated input: checks latency edges, the result, and hold afterwards
    task automatic single(input string tag, input int d, input int ed, input int x,
                          input int sh, input bit neg, input bit dz);
        rst_n  = 1'b1;
        in_vld = 1'b1;
        in_d   = 18'(d);
        step();
        in_vld = 1'b0;
        in_d   = '0;
        step();
        step();
        chk({tag, ".early"}, {31'b0, out_vld}, 32'd0);
        step();
        chk_res(tag, ed, x, sh, neg, dz);
        step();
        chk({tag, ".one_cycle"}, {31'b0, out_vld}, 32'd0);
        chk({tag, ".hold_d"}, {14'b0, out_d}, {14'b0, 18'(ed)});
        chk({tag, ".hold_x"}, {14'b0, out_x}, {14'b0, 18'(x)});
    endtask

    initial begin
        rst_n  = 1'b0;
        in_vld = 1'b1;
        in_d   = 18'd128;
        step();
        step();
        chk("rst.vld",   {31'b0, out_vld}, 32'd0);
        chk("rst.d",     {14'b0, out_d},   32'd0);
        chk("rst.x",     {14'b0, out_x},   32'd0);
        chk("rst.shift", {26'b0, out_shift}, 32'd0);
        chk("rst.neg",   {31'b0, out_neg}, 32'd0);
        chk("rst.dz",    {31'b0, out_dz},  32'd0);

        // First edge with rst_n=1 accepts the input
        single("d128",  128,     64,  241,  1, 1'b0, 1'b0);
        single("d384",  384,     96,  181,  2, 1'b0, 1'b0);
        single("d32",   32,      64,  241, -1, 1'b0, 1'b0);
        single("dm128", -128,    64,  241,  1, 1'b1, 1'b0);
        single("dmin",  -131072, 127, 122, 10, 1'b1, 1'b0);
        single("d0",    0,       0,   0,    0, 1'b0, 1'b1);
        single("d1",    1,       64,  241, -6, 1'b0, 1'b0);

        // Back-to-back stream
        in_vld = 1'b1;
        in_d = 18'd128;  step();
        in_d = 18'd384;  step();
        in_d = 18'd32;   step();
        in_d = 18'd0;    step();
        in_vld = 1'b0;
        in_d   = '0;
        chk_res("b2b0", 64, 241, 1, 1'b0, 1'b0);
        step();
        chk_res("b2b1", 96, 181, 2, 1'b0, 1'b0);
        step();
        chk_res("b2b2", 64, 241, -1, 1'b0, 1'b0);
        step();
        chk_res("b2b3", 0, 0, 0, 1'b0, 1'b1);
        step();
        chk("b2b.end", {31'b0, out_vld}, 32'd0);

        // Reset with two inputs in flight
        in_vld = 1'b1;
        in_d = 18'd384; step();
        in_d = 18'd32;  step();
        rst_n = 1'b0;
        in_d  = 18'd0;
        step();
        chk("mid.rst_vld", {31'b0, out_vld}, 32'd0);
        chk("mid.rst_d",   {14'b0, out_d},   32'd0);
        rst_n = 1'b1;
        in_d  = 18'(-128);
        step();
        in_vld = 1'b0;
        in_d   = '0;
        chk("mid.flush0", {31'b0, out_vld}, 32'd0);
        step();
        chk("mid.flush1", {31'b0, out_vld}, 32'd0);
        step();
        chk("mid.flush2", {31'b0, out_vld}, 32'd0);
        step();
        chk_res("mid.after", 64, 241, 1, 1'b1, 1'b0);
        step();
        chk("mid.end", {31'b0, out_vld}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
